// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: radix-2 FFT stage/butterfly issue sequencer with ping-pong bank select.
// Define FFT_CYCLE_COUNT_EN to add the 32-bit busy-cycle counter output cycle_count.
module fft_stage_sequencer #(
  parameter int FFT_N          = 10,
  parameter int STAGE_COUNT_BW = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      hold,
  output logic                      busy,
  output logic                      done,
  output logic [STAGE_COUNT_BW-1:0] fft_stage,
  output logic                      bf_iact,
  output logic [1:0]                bf_ictrl,
  output logic [FFT_N-2:0]          bf_addr,
  output logic [FFT_N-2:0]          twiddle_addr,
  output logic                      bank_sel,
  input  logic                      bf_oact,
  output logic                      err
`ifdef FFT_CYCLE_COUNT_EN
  ,
  output logic [31:0]               cycle_count
`endif
);
  localparam int KW = FFT_N - 1;
  localparam logic [KW-1:0] K_LAST = '1;
  localparam logic [FFT_N-1:0] N_HALF = {1'b1, {KW{1'b0}}};
  localparam logic [FFT_N-1:0] N_PRE = {1'b0, {KW{1'b1}}};
  localparam logic [STAGE_COUNT_BW-1:0] S_LAST = STAGE_COUNT_BW'(FFT_N - 1);
  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, NEXT, FIN} state_t;
  state_t state_q, state_d;
  logic [KW-1:0] k_q, k_d, mask;
  logic [STAGE_COUNT_BW-1:0] stage_q, stage_d;
  logic [FFT_N-1:0] cnt_q, cnt_d;
  logic bank_q, bank_d, err_q, err_d, full, drained;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
  assign bf_iact = state_q == ISSUE && !hold;
  assign bf_ictrl = bf_iact ? {k_q == K_LAST, k_q == '0} : 2'b00;
  assign bf_addr = k_q;
  assign fft_stage = stage_q;
  assign bank_sel = bank_q;
  assign err = err_q;
  // Twiddle index keeps the low s bits of k, scaled up to the full ROM range.
  assign mask = ~({KW{1'b1}} << stage_q);
  assign twiddle_addr = (k_q & mask) << (KW - int'(stage_q));
  assign full = cnt_q == N_HALF;
  assign drained = full || (cnt_q == N_PRE && bf_oact);
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    stage_d = stage_q;
    bank_d = bank_q;
    cnt_d = (busy && bf_oact && !full) ? cnt_q + 1'b1 : cnt_q;
    err_d = err_q || (bf_oact && (!busy || full));
    case (state_q)
      IDLE: state_d = start ? ISSUE : IDLE;
      ISSUE: begin
        k_d = bf_iact ? k_q + 1'b1 : k_q;
        state_d = (bf_iact && k_q == K_LAST) ? DRAIN : ISSUE;
      end
      DRAIN: begin
        state_d = drained ? NEXT : DRAIN;
        cnt_d = drained ? '0 : cnt_d;
      end
      NEXT: begin
        bank_d = ~bank_q;
        state_d = (stage_q == S_LAST) ? FIN : ISSUE;
        stage_d = (stage_q == S_LAST) ? stage_q : stage_q + 1'b1;
      end
      FIN: begin
        state_d = IDLE;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      stage_q <= '0;
      bank_q <= 1'b0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      stage_q <= stage_d;
      bank_q <= bank_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`ifdef FFT_CYCLE_COUNT_EN
  logic [31:0] cc_q, cc_d;
  assign cycle_count = cc_q;
  assign cc_d = (state_q == IDLE && start) ? '0 : (busy && cc_q != '1) ? cc_q + 1'b1 : cc_q;
  always_ff @(posedge clk) begin
    if (reset) cc_q <= '0;
    else cc_q <= cc_d;
  end
`endif
endmodule
